// File: rtl/sd_uart_pkg.sv
// Shared UART transmit types and constants used by sd_uart_tx and the SD/UART command controller.
// Also holds the line-level decode used by the transmitter's FSM.
package sd_uart_pkg;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_t;

  localparam int         UART_DATA_BITS  = 8;
  localparam logic       UART_IDLE_LEVEL = 1'b1;
  localparam logic [7:0] UART_START_BYTE = 8'hA5;

  // Command bytes the controller exchanges with the host
  localparam logic [7:0] CMD_READ_CID   = 8'h43;
  localparam logic [7:0] CMD_READ_CSD   = 8'h44;
  localparam logic [7:0] CMD_READ_BLOCK = 8'h52;
  localparam logic [7:0] CMD_STATUS     = 8'h53;

  function automatic logic tx_line_level(input tx_state_t st, input logic lsb);
    case (st)
      TX_START: return 1'b0;
      TX_DATA:  return lsb;
      default:  return UART_IDLE_LEVEL;
    endcase
  endfunction

endpackage

// File: rtl/sd_uart_fifo.sv
// Byte FIFO: push/pop take effect on the clock edge; head_dat shows the oldest byte combinationally.
// Backpressure: a push while full is dropped and sets the sticky overflow flag; clear wins over push/pop.
module sd_uart_fifo #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4,
  parameter int WIDTH  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [WIDTH-1:0]  push_dat,
  input  logic              pop,
  input  logic              clear,
  output logic [WIDTH-1:0]  head_dat,
  output logic              full,
  output logic              empty,
  output logic              overflow,
  output logic [ADDR_W:0]   count
);

  logic [WIDTH-1:0]  mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign full     = (count == (ADDR_W+1)'(DEPTH));
  assign empty    = (count == '0);
  assign head_dat = mem[rd_ptr];
  // Fullness is judged on the pre-edge count, so a same-edge pop never rescues a push
  assign do_push  = push && !full && !clear;
  assign do_pop   = pop && !empty && !clear;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (clear) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push && full) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

endmodule

// File: rtl/sd_uart_tx.sv
// UART 8N1 transmitter fed by a byte FIFO; txd falls one cycle after the first push, frames run back-to-back.
// Backpressure: tx_full/tx_count tell the controller to stop; pushes while full are dropped and flagged.
module sd_uart_tx
  import sd_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 16,
  parameter int ADDR_W       = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tx_en,
  input  logic [7:0]        tx_data,
  input  logic              tx_clear,
  output logic              txd,
  output logic              tx_full,
  output logic              tx_empty,
  output logic              tx_busy,
  output logic              tx_overflow,
  output logic [ADDR_W:0]   tx_count
);

  localparam int              CNT_W     = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       BIT_LAST  = 3'(UART_DATA_BITS - 1);

  tx_state_t        state, state_nxt;
  logic [CNT_W-1:0] baud_cnt, baud_nxt;
  logic [2:0]       bit_idx, bit_nxt;
  logic [7:0]       shift, shift_nxt;
  logic [7:0]       head_dat;
  logic             fifo_pop;
  logic             bit_done;
  logic             can_load;

  sd_uart_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .ADDR_W (ADDR_W),
    .WIDTH  (8)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (tx_en),
    .push_dat (tx_data),
    .pop      (fifo_pop),
    .clear    (tx_clear),
    .head_dat (head_dat),
    .full     (tx_full),
    .empty    (tx_empty),
    .overflow (tx_overflow),
    .count    (tx_count)
  );

  assign bit_done = (baud_cnt == BAUD_LAST);
  // A flush on the same edge must not launch the byte it is discarding
  assign can_load = !tx_empty && !tx_clear;
  assign tx_busy  = (state != TX_IDLE);
  assign txd      = tx_line_level(state, shift[0]);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= TX_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
    end else begin
      state    <= state_nxt;
      baud_cnt <= baud_nxt;
      bit_idx  <= bit_nxt;
      shift    <= shift_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    baud_nxt  = baud_cnt;
    bit_nxt   = bit_idx;
    shift_nxt = shift;
    fifo_pop  = 1'b0;
    case (state)
      TX_IDLE: begin
        baud_nxt = '0;
        if (can_load) begin
          fifo_pop  = 1'b1;
          shift_nxt = head_dat;
          state_nxt = TX_START;
        end
      end
      TX_START: begin
        if (bit_done) begin
          baud_nxt  = '0;
          bit_nxt   = '0;
          state_nxt = TX_DATA;
        end else begin
          baud_nxt = baud_cnt + 1'b1;
        end
      end
      TX_DATA: begin
        if (bit_done) begin
          baud_nxt  = '0;
          shift_nxt = {1'b0, shift[7:1]};
          if (bit_idx == BIT_LAST) state_nxt = TX_STOP;
          else                     bit_nxt   = bit_idx + 1'b1;
        end else begin
          baud_nxt = baud_cnt + 1'b1;
        end
      end
      TX_STOP: begin
        if (bit_done) begin
          baud_nxt = '0;
          if (can_load) begin
            fifo_pop  = 1'b1;
            shift_nxt = head_dat;
            state_nxt = TX_START;
          end else begin
            state_nxt = TX_IDLE;
          end
        end else begin
          baud_nxt = baud_cnt + 1'b1;
        end
      end
      default: state_nxt = TX_IDLE;
    endcase
  end

endmodule
